// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between icache refills and dcache
// refills/writebacks for a single whole-line main-memory port.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   ic_req/ic_addr       icache line-read request, held until ic_done
//   ic_done/ic_rdata     icache completion pulse and read line
//   dc_req/dc_we         dcache request, 1 = writeback, 0 = refill
//   dc_addr/dc_wdata     dcache line address and writeback line
//   dc_done/dc_rdata     dcache completion pulse and refill line
//   mem_req/mem_we       one-cycle strobe and direction to memory
//   mem_addr/mem_wdata   line-aligned address and write line
//   mem_done/mem_rdata   memory completion pulse and read line
//   err                  sticky: timeout or unexpected mem_done
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 64,
  parameter int LINE_BITS  = LINE_BYTES * 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_done,
  output logic [LINE_BITS-1:0]  ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_BITS-1:0]  dc_wdata,
  output logic                  dc_done,
  output logic [LINE_BITS-1:0]  dc_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_BITS-1:0]  mem_wdata,
  input  logic                  mem_done,
  input  logic [LINE_BITS-1:0]  mem_rdata,
  output logic                  err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ~ADDR_WIDTH'(LINE_BYTES - 1);

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic                  last_dc;
  logic                  gnt_dc;
  logic                  pick_dc;
  logic [ADDR_WIDTH-1:0] sel_addr;

  // dcache wins when alone, or on a tie when icache had the last grant
  assign pick_dc  = dc_req & (~ic_req | ~last_dc);
  assign sel_addr = pick_dc ? dc_addr : ic_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dc   <= 1'b0;
      gnt_dc    <= 1'b0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_done) err <= 1'b1;
          if (ic_req || dc_req) begin
            gnt_dc    <= pick_dc;
            last_dc   <= pick_dc;
            mem_we    <= pick_dc & dc_we;
            mem_addr  <= sel_addr & AMASK;
            mem_wdata <= pick_dc ? dc_wdata : '0;
            mem_req   <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_done) err <= 1'b1;
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            if (gnt_dc) dc_rdata <= mem_rdata;
            else        ic_rdata <= mem_rdata;
            dc_done <= gnt_dc;
            ic_done <= ~gnt_dc;
            state   <= DONE;
          end else if (cnt == CNT_MAX) begin
            err <= 1'b1;
            if (gnt_dc) dc_rdata <= '0;
            else        ic_rdata <= '0;
            dc_done <= gnt_dc;
            ic_done <= ~gnt_dc;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (mem_done) err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// Requester and memory models drive the DUT; monitors check outputs.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int LB  = 512;
  localparam int TMO = 16;

  logic          clk;
  logic          rst_n;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_done;
  logic [LB-1:0] ic_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [LB-1:0] dc_wdata;
  logic          dc_done;
  logic [LB-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LB-1:0] mem_wdata;
  logic          mem_done;
  logic [LB-1:0] mem_rdata;
  logic          err;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .LINE_BYTES(64),
    .LINE_BITS (LB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ic_req   (ic_req),
    .ic_addr  (ic_addr),
    .ic_done  (ic_done),
    .ic_rdata (ic_rdata),
    .dc_req   (dc_req),
    .dc_we    (dc_we),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_done  (dc_done),
    .dc_rdata (dc_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_done (mem_done),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  typedef struct {
    bit            dc;
    bit            we;
    logic [AW-1:0] addr;
    logic [LB-1:0] wdata;
    logic [LB-1:0] rdata;
    int            lat;
    bit            err;
  } tx_t;

  tx_t icq[$];
  tx_t dcq[$];
  tx_t mexp[$];
  tx_t dexp[$];
  tx_t rq[$];
  int  reqcyc[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit m_last_dc = 0;
  bit m_err = 0;
  bit stray_pend = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm,
                     input logic [LB-1:0] act,
                     input logic [LB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] v;
    for (int k = 0; k < LB / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic tx_t mk(input bit dc, input bit we,
                             input logic [AW-1:0] a, input int lat);
    tx_t t;
    t.dc    = dc;
    t.we    = we;
    t.addr  = a;
    t.wdata = rand_line();
    t.rdata = rand_line();
    t.lat   = lat;
    t.err   = 0;
    return t;
  endfunction

  // Expected memory transaction and completion for a granted request
  task automatic push_exp(input tx_t t);
    tx_t e;
    e = t;
    e.we = t.dc & t.we;
    e.addr = t.addr & 32'hffff_ffc0;
    if (t.lat < 0) begin
      m_err = 1;
      e.rdata = '0;
    end
    e.err = m_err;
    mexp.push_back(e);
    dexp.push_back(e);
    rq.push_back(e);
  endtask

  task automatic req_proc(input bit is_dc);
    tx_t t;
    int n;
    while (is_dc ? (dcq.size() > 0) : (icq.size() > 0)) begin
      if (is_dc) t = dcq.pop_front();
      else       t = icq.pop_front();
      @(negedge clk);
      if (is_dc) begin
        dc_req = 1; dc_we = t.we;
        dc_addr = t.addr; dc_wdata = t.wdata;
      end else begin
        ic_req = 1; ic_addr = t.addr;
      end
      n = 0;
      while (!(is_dc ? dc_done : ic_done) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_wait: dc=%0d no done after %0d", is_dc, n);
      end
      if (is_dc) dc_req = 0;
      else       ic_req = 0;
    end
  endtask

  // Grant order from the arbitration rules: alone wins, tie alternates
  task automatic run_batch();
    int i = 0;
    int j = 0;
    bit pd;
    while (i < icq.size() || j < dcq.size()) begin
      if (i < icq.size() && j < dcq.size()) pd = !m_last_dc;
      else pd = (j < dcq.size());
      m_last_dc = pd;
      if (pd) begin push_exp(dcq[j]); j++; end
      else    begin push_exp(icq[i]); i++; end
    end
    fork
      req_proc(1'b0);
      req_proc(1'b1);
    join
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ic_done"},   ic_done,   '0);
    chk({tag, "_dc_done"},   dc_done,   '0);
    chk({tag, "_ic_rdata"},  ic_rdata,  '0);
    chk({tag, "_dc_rdata"},  dc_rdata,  '0);
    chk({tag, "_mem_req"},   mem_req,   '0);
    chk({tag, "_mem_we"},    mem_we,    '0);
    chk({tag, "_mem_addr"},  mem_addr,  '0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chk({tag, "_err"},       err,       '0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 0;
    ic_req = 0;
    dc_req = 0;
    @(negedge clk);
    chk_reset(tag);
    rst_n = 1;
    m_last_dc = 0;
    m_err = 0;
    reqcyc.delete();
  endtask

  task automatic stray();
    int n = 0;
    stray_pend = 1;
    while (stray_pend && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    m_err = 1;
    chk("stray_err", err, 1'b1);
  endtask

  // Memory model: answers each strobe after the planned latency
  initial begin
    tx_t e;
    mem_done = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && rq.size() > 0) begin
        e = rq.pop_front();
        if (e.lat > 0) begin
          repeat (e.lat) @(negedge clk);
          mem_done = 1;
          mem_rdata = e.rdata;
          @(negedge clk);
          mem_done = 0;
          mem_rdata = rand_line();
        end
      end else if (stray_pend) begin
        mem_done = 1;
        @(negedge clk);
        mem_done = 0;
        stray_pend = 0;
      end else begin
        mem_rdata = rand_line();
      end
    end
  end

  // Memory-side monitor
  initial begin
    tx_t e;
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (mem_req && rst_n) begin
        chk("mem_req_pulse", prev, 1'b0);
        if (mexp.size() == 0) begin
          chk("mem_req_unexpected", 1'b1, 1'b0);
        end else begin
          e = mexp.pop_front();
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          reqcyc.push_back(cyc);
        end
      end
      prev = mem_req;
    end
  end

  // Completion monitor
  initial begin
    tx_t e;
    int rc;
    forever begin
      @(negedge clk);
      if (ic_done || dc_done) begin
        chk("done_both", ic_done & dc_done, 1'b0);
        if (dexp.size() == 0) begin
          chk("done_unexpected", 1'b1, 1'b0);
        end else begin
          e = dexp.pop_front();
          rc = (reqcyc.size() > 0) ? reqcyc.pop_front() : -1000;
          chk("done_who", dc_done, e.dc);
          if (e.dc && !e.we) chk("dc_rdata", dc_rdata, e.rdata);
          if (!e.dc) chk("ic_rdata", ic_rdata, e.rdata);
          chk("done_err", err, e.err);
          chk("done_delay", cyc - rc,
              (e.lat < 0) ? 1 + TMO : 1 + e.lat);
          chk("mem_addr_hold", mem_addr, e.addr);
        end
      end
    end
  end

  initial begin
    tx_t t;
    int n;
    rst_n = 0;
    ic_req = 0; ic_addr = '0;
    dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1;

    icq.push_back(mk(0, 0, 32'h0000_1234, 3));
    run_batch();

    icq.push_back(mk(0, 0, $urandom, $urandom_range(1, 6)));
    t = mk(1, 1, 32'h0000_0040, $urandom_range(1, 6));
    dcq.push_back(t);
    run_batch();
    dcq.push_back(mk(1, 0, $urandom, 1));
    run_batch();
    icq.push_back(mk(0, 0, $urandom, 1));
    dcq.push_back(mk(1, $urandom_range(0, 1), $urandom, 2));
    run_batch();

    for (int k = 0; k < 4; k++) begin
      icq.push_back(mk(0, 0, $urandom, $urandom_range(1, 6)));
      dcq.push_back(mk(1, $urandom_range(0, 1), $urandom,
                       $urandom_range(1, 6)));
    end
    run_batch();

    for (int b = 0; b < 6; b++) begin
      int ni = $urandom_range(0, 3);
      int nd = $urandom_range(ni == 0 ? 1 : 0, 3);
      for (int k = 0; k < ni; k++)
        icq.push_back(mk(0, 0, $urandom, $urandom_range(1, 8)));
      for (int k = 0; k < nd; k++)
        dcq.push_back(mk(1, $urandom_range(0, 1), $urandom,
                         $urandom_range(1, 8)));
      run_batch();
    end

    dcq.push_back(mk(1, 0, $urandom, -1));
    run_batch();
    dcq.push_back(mk(1, 0, $urandom, 4));
    run_batch();
    @(negedge clk);
    chk("err_sticky", err, 1'b1);

    do_reset("rst1");
    stray();
    repeat (4) @(negedge clk);
    chk("stray_no_req", mem_req, 1'b0);
    icq.push_back(mk(0, 0, $urandom, 2));
    run_batch();

    do_reset("rst2");
    t = mk(0, 0, $urandom, -1);
    t.addr = t.addr & 32'hffff_ffc0;
    mexp.push_back(t);
    rq.push_back(t);
    @(negedge clk);
    ic_req = 1;
    ic_addr = t.addr;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midwait_issue", mem_req, 1'b1);
    ic_req = 0;
    repeat (3) @(negedge clk);
    do_reset("rst3");
    stray();
    icq.push_back(mk(0, 0, $urandom, 3));
    run_batch();

    n = 0;
    while (dexp.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", dexp.size(), 0);
    chk("drain_mem", mexp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
